// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage hazard controller: stall, rs/rt forwarding selects and mul/div busy tracking
module hazard_scoreboard #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_wa,
    input  logic [1:0] D_Tnew,
    input  logic [1:0] D_md_op,
    input  logic       D_uses_hilo,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       md_busy
);

    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
    } rec_t;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    rec_t       e_rec;
    rec_t       m_rec;
    rec_t       w_rec;
    logic [1:0] e_md;
    logic [3:0] md_cnt;

    logic [2:0] rs_res;
    logic [2:0] rt_res;
    logic       hilo_stall;
    logic [1:0] d_md;

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Returns {stall, sel}; the nearest matching stage alone decides both.
    function automatic logic [2:0] resolve(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input rec_t       e,
        input rec_t       m,
        input rec_t       w
    );
        logic       hit;
        logic [1:0] tn;
        logic [1:0] sel;
        hit = 1'b0;
        tn  = 2'd0;
        sel = 2'b00;
        if (r != 5'd0) begin
            if (e.wa == r) begin
                hit = 1'b1;
                tn  = e.tnew;
                sel = 2'b01;
            end else if (m.wa == r) begin
                hit = 1'b1;
                tn  = m.tnew;
                sel = 2'b10;
            end else if (w.wa == r) begin
                hit = 1'b1;
                tn  = w.tnew;
                sel = 2'b11;
            end
        end
        return {hit && (tuse != 2'd3) && (tn > tuse),
                (hit && tn == 2'd0) ? sel : 2'b00};
    endfunction

    always_comb begin
        d_md       = (D_md_op == 2'b11) ? MD_NONE : D_md_op;
        rs_res     = resolve(D_rs, D_Tuse_rs, e_rec, m_rec, w_rec);
        rt_res     = resolve(D_rt, D_Tuse_rt, e_rec, m_rec, w_rec);
        md_busy    = (md_cnt != 4'd0);
        hilo_stall = D_uses_hilo && (md_busy || (e_md != MD_NONE));
        stall      = rs_res[2] || rt_res[2] || hilo_stall;
        fwd_rs_sel = rs_res[1:0];
        fwd_rt_sel = rt_res[1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rec  <= '0;
            m_rec  <= '0;
            w_rec  <= '0;
            e_md   <= MD_NONE;
            md_cnt <= 4'd0;
        end else begin
            w_rec <= '{wa: m_rec.wa, tnew: dec_sat(m_rec.tnew)};
            m_rec <= '{wa: e_rec.wa, tnew: dec_sat(e_rec.tnew)};
            if (stall) begin
                e_rec <= '0;
                e_md  <= MD_NONE;
            end else begin
                e_rec <= '{wa: D_wa, tnew: D_Tnew};
                e_md  <= d_md;
            end
            // A new mul/div leaving E restarts the busy window even if one is running.
            if (e_md == MD_MULT) begin
                md_cnt <= 4'(MULT_CYC);
            end else if (e_md == MD_DIV) begin
                md_cnt <= 4'(DIV_CYC);
            end else if (md_cnt != 4'd0) begin
                md_cnt <= md_cnt - 4'd1;
            end
        end
    end

endmodule
